cpu_irq_ctrl: RTL and testbench
===============================

// Module: cpu_irq_ctrl
// PURPOSE
//  Interrupt/exception arbiter directly upstream of the PC source mux in the single-cycle CPU.
//  Latches external interrupt edges, applies a mask, and forces PCSrc to 3'd4 (ILLOP, interrupt) or 3'd5 (XADR, exception).
//  Supplies the return address (EPC) for the $k0 write-back.
//  Kernel mode is PC[31]=1; interrupts are taken only in user mode.
// PARAMETERS
//  N_IRQ   8   number of external interrupt lines (1..16)
// PORTS
//  clk         in   1      CPU clock
//  reset       in   1      synchronous, active-low reset
//  PC          in   32     current PC (same cycle as the PC mux input)
//  illop       in   1      decoder flags an undefined opcode this cycle
//  irq_in      in   N_IRQ  external interrupt lines, level, rising edge = request
//  reg_we      in   1      register write strobe
//  reg_addr    in   2      0=MASK, 1=PENDING (write-1-to-clear), 2=CAUSE (read-only)
//  reg_wdata   in   32     write data (low N_IRQ bits used)
//  reg_rdata   out  32     read data, combinational from reg_addr, zero-extended
//  force_en    out  1      1 = PC mux must use force_src instead of the decoder PCSrc
//  force_src   out  3      3'd4 interrupt, 3'd5 exception, else 3'd0
//  epc         out  32     return address for $k0
//  epc_we      out  1      one-cycle write pulse for $k0 <= epc
// BEHAVIOUR
//  Clock and reset:
//   - All state is updated on posedge clk.
//   - reset==0 at a clock edge clears mask, pending, cause, irq_q, FSM=USER.
//   - While reset==0, force_en, epc_we and force_src are 0 and epc is 0.
//   - Reset applied mid-operation (including in KERNEL) returns the block to USER with nothing pending.
//  Edge detection:
//   - irq_q <= irq_in.
//   - rise = irq_in & ~irq_q; pending <= pending | rise.
//  Arbitration (combinational):
//   - req = pending & mask.
//   - sel = lowest set index of req.
//   - exc = illop.
//   - irq = (|req) & ~PC[31] & (state==USER).
//  Priority:
//   - An exception beats an interrupt in the same cycle.
//   - Exceptions are taken in any mode.
//  take_exc:
//   - force_en=1, force_src=5.
//   - epc = {PC[31], PC[30:0]+4}; the faulting instruction is skipped.
//   - epc_we=1.
//  take_irq (only when there is no exception that cycle):
//   - force_en=1, force_src=4.
//   - epc = PC; the interrupted instruction has not executed and is replayed.
//   - epc_we=1.
//   - On the clock edge: cause <= sel; pending[sel] cleared.
//  Outputs are combinational from the current inputs.
//   - The PC mux loads the vector on the same edge, giving zero-cycle latency.
//   - epc_we is high for exactly that one cycle.
//  FSM:
//   - USER --take_irq|take_exc--> KERNEL.
//   - KERNEL --PC[31]==0 observed--> USER (a jr to a user address).
//   - An exception in KERNEL stays in KERNEL.
//   - No nested interrupts: irq is gated off while in KERNEL.
//  Same-cycle collisions:
//   - New rise on line k in the same cycle as the ack of line k -> pending[k] stays 1.
//   - PENDING w1c in the same cycle as a rise on the same bit -> the rise wins.
//   - MASK write takes effect from the next cycle.
//  Register map:
//   - MASK: read/write.
//   - PENDING: read = pending; write clears the bits written as 1.
//   - CAUSE: read = {28'b0, cause}.
//   - reg_addr 3: reads 0; writes are ignored.
//  Widths:
//   - PC+4 wraps inside bits [30:0] only; bit 31 is preserved.
//   - cause is 4 bits.
// CONFIGURATION
//  CPU_IRQ_SYNC_EN defined:
//   - irq_in passes through a 2-flop synchronizer before edge detection.
//   - Request-to-pending latency is 3 edges.
//   - Synchronizer flops reset to 0.
//  CPU_IRQ_SYNC_EN undefined:
//   - No synchronizer; pending is set on the first edge after the rise (1 edge).
// TESTING
//  1. Reset: hold reset=0 for 2 clocks with irq_in toggling -> force_en=0, reg_rdata=0 for every address; pending=0 after release.
//  2. Basic interrupt:
//     - Stimulus: MASK=8'h01, PC=32'h0000_0040, rise on irq_in[0].
//     - Next cycle: force_en=1, force_src=4, epc=32'h0000_0040, epc_we=1.
//     - Then: CAUSE=0, PENDING=0.
//  3. Priority and masking:
//     - Stimulus: MASK=8'h0C, rise on lines 1, 2 and 3 in one cycle.
//     - Response: line 2 taken first (cause=2), line 1 stays pending, unserviced.
//     - Then PC returns to 0x0000_0100: line 3 taken (cause=3).
//  4. Exception beats interrupt: illop=1 with PC=32'h0000_1000 and req pending -> force_src=5, epc=32'h0000_1004, pending unchanged.
//  5. Kernel gating:
//     - Stimulus: PC=32'h8000_0020 with req pending.
//     - Response: force_en=0 until PC=32'h0000_2000, then force_src=4 on that cycle.
//     - illop in kernel -> force_src=5, epc=32'h8000_0024.
//  6. Collisions:
//     - Rise on line k during its ack -> pending[k]=1.
//     - PENDING w1c on a rising bit -> bit stays 1.
//     - Repeat with CPU_IRQ_SYNC_EN defined; check the 3-edge latency.

Source files
------------

// File: rtl/cpu_irq_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : cpu_irq_ctrl                                                |
// | Purpose  : Interrupt/exception arbiter in front of the PC source mux.  |
// |            Latches rising edges of the external interrupt lines and    |
// |            applies a mask. Overrides PCSrc with 4 (interrupt) or 5     |
// |            (exception) and supplies the EPC for the $k0 write-back.    |
// |            Kernel mode is PC[31]=1; interrupts are taken only from     |
// |            user mode and never nest.                                   |
// | Ports    : clk, reset (sync, active-low)                               |
// |            PC[31:0], illop             - CPU state this cycle          |
// |            irq_in[N_IRQ-1:0]           - external lines, rising edge   |
// |            reg_we, reg_addr[1:0],      - 0=MASK, 1=PENDING (w1c),      |
// |            reg_wdata[31:0], reg_rdata  - 2=CAUSE, 3=reads zero         |
// |            force_en, force_src[2:0]    - PC mux override               |
// |            epc[31:0], epc_we           - $k0 return address + strobe   |
// | Config   : CPU_IRQ_SYNC_EN - adds a 2-flop synchronizer on irq_in      |
// |            (request-to-pending latency 3 edges instead of 1).          |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module cpu_irq_ctrl #(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      PC,
  input  logic             illop,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             force_en,
  output logic [2:0]       force_src,
  output logic [31:0]      epc,
  output logic             epc_we
);

  localparam logic [2:0] c_SRC_NONE = 3'd0;
  localparam logic [2:0] c_SRC_IRQ  = 3'd4;
  localparam logic [2:0] c_SRC_EXC  = 3'd5;

  localparam logic [1:0] c_ADDR_MASK    = 2'd0;
  localparam logic [1:0] c_ADDR_PENDING = 2'd1;
  localparam logic [1:0] c_ADDR_CAUSE   = 2'd2;

  typedef enum logic [0:0] {
    ST_USER   = 1'b0,
    ST_KERNEL = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_IRQ-1:0] r_mask;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_irq_q;
  logic [3:0]       r_cause;

  logic [N_IRQ-1:0] w_irq_s;
  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_req;
  logic [N_IRQ-1:0] w_ack;
  logic [N_IRQ-1:0] w_w1c;
  logic [N_IRQ-1:0] w_pending_nxt;
  logic [3:0]       w_sel;
  logic             w_take_exc;
  logic             w_take_irq;
  logic             w_unused_wdata;

`ifdef CPU_IRQ_SYNC_EN
  logic [N_IRQ-1:0] r_sync1;
  logic [N_IRQ-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq_s = r_sync2;
`else
  assign w_irq_s = irq_in;
`endif

  assign w_unused_wdata = ^reg_wdata[31:N_IRQ];

  assign w_rise = w_irq_s & ~r_irq_q;
  assign w_req  = r_pending & r_mask;
  assign w_w1c  = (reg_we && reg_addr == c_ADDR_PENDING) ? reg_wdata[N_IRQ-1:0] : '0;

  // Decisions are qualified by reset so the outputs stay quiet while it is held.
  assign w_take_exc = reset & illop;
  assign w_take_irq = reset & ~illop & (|w_req) & ~PC[31] & (r_state == ST_USER);

  // Lowest-index request wins; scanning downwards leaves the lowest one last.
  always_comb begin
    w_sel = 4'd0;
    w_ack = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_sel    = i[3:0];
        w_ack    = '0;
        w_ack[i] = 1'b1;
      end
    end
  end

  // A new rise always survives both the acknowledge and a w1c on the same bit.
  assign w_pending_nxt = (r_pending & ~(w_take_irq ? w_ack : '0) & ~w_w1c) | w_rise;

  always_comb begin
    force_en    = 1'b0;
    force_src   = c_SRC_NONE;
    epc         = 32'd0;
    epc_we      = 1'b0;
    w_state_nxt = r_state;
    if (w_take_exc) begin
      // Faulting instruction is skipped; the +4 never carries into the mode bit.
      force_en    = 1'b1;
      force_src   = c_SRC_EXC;
      epc         = {PC[31], PC[30:0] + 31'd4};
      epc_we      = 1'b1;
      w_state_nxt = ST_KERNEL;
    end else if (w_take_irq) begin
      // Interrupted instruction has not executed yet and is replayed.
      force_en    = 1'b1;
      force_src   = c_SRC_IRQ;
      epc         = PC;
      epc_we      = 1'b1;
      w_state_nxt = ST_KERNEL;
    end else if (r_state == ST_KERNEL && !PC[31]) begin
      w_state_nxt = ST_USER;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_USER;
      r_mask    <= '0;
      r_pending <= '0;
      r_irq_q   <= '0;
      r_cause   <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_irq_q   <= w_irq_s;
      r_pending <= w_pending_nxt;
      if (reg_we && reg_addr == c_ADDR_MASK) begin
        r_mask <= reg_wdata[N_IRQ-1:0];
      end
      if (w_take_irq) begin
        r_cause <= w_sel;
      end
    end
  end

  always_comb begin
    reg_rdata = 32'd0;
    case (reg_addr)
      c_ADDR_MASK:    reg_rdata[N_IRQ-1:0] = r_mask;
      c_ADDR_PENDING: reg_rdata[N_IRQ-1:0] = r_pending;
      c_ADDR_CAUSE:   reg_rdata[3:0]       = r_cause;
      default:        reg_rdata            = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_irq_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_cpu_irq_ctrl                                             |
// | Purpose  : Self-checking bench for cpu_irq_ctrl. Expected PC-mux       |
// |            overrides are queued by the scenario tasks and consumed by  |
// |            a negedge monitor; register reads are checked inline.       |
// |            Honours CPU_IRQ_SYNC_EN for the request latency.            |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_cpu_irq_ctrl;

  localparam int N_IRQ = 8;
`ifdef CPU_IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [31:0]      PC = 32'd0;
  logic             illop = 1'b0;
  logic [N_IRQ-1:0] irq_in = '0;
  logic             reg_we = 1'b0;
  logic [1:0]       reg_addr = 2'd0;
  logic [31:0]      reg_wdata = 32'd0;
  logic [31:0]      reg_rdata;
  logic             force_en;
  logic [2:0]       force_src;
  logic [31:0]      epc;
  logic             epc_we;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [2:0]  src;
    logic [31:0] epc;
  } exp_t;

  exp_t sb[$];

  cpu_irq_ctrl #(.N_IRQ(N_IRQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .PC        (PC),
    .illop     (illop),
    .irq_in    (irq_in),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .force_en  (force_en),
    .force_src (force_src),
    .epc       (epc),
    .epc_we    (epc_we)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every override must match the next queued expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (force_en || epc_we) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_force: cycle %0d force_src=%0d epc=%h, required no override",
                   cyc, force_src, epc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.cyc !== cyc || force_en !== 1'b1 || epc_we !== 1'b1 ||
              force_src !== e.src || epc !== e.epc) begin
            errors++;
            $display("FAIL force_cmp: got cyc=%0d en=%b we=%b src=%0d epc=%h, want cyc=%0d en=1 we=1 src=%0d epc=%h",
                     cyc, force_en, epc_we, force_src, epc, e.cyc, e.src, e.epc);
          end
        end
      end else begin
        checks++;
        if (force_src !== 3'd0 || force_en !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs: got en=%b src=%0d, want en=0 src=0", force_en, force_src);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_force(input logic [2:0] src, input logic [31:0] ret);
    exp_t e;
    e.cyc = cyc;
    e.src = src;
    e.epc = ret;
    sb.push_back(e);
  endtask

  task automatic return_user(input logic [31:0] upc);
    PC = 32'h8000_0080;
    tick();
    PC = upc;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    illop = 1'b1;
    PC    = 32'h0000_0040;
    for (int i = 0; i < 2; i++) begin
      irq_in = N_IRQ'($urandom);
      tick();
      checks++;
      if (force_en !== 1'b0 || epc_we !== 1'b0 || force_src !== 3'd0 || epc !== 32'd0) begin
        errors++;
        $display("FAIL reset_outputs: got en=%b we=%b src=%0d epc=%h, want all 0",
                 force_en, epc_we, force_src, epc);
      end
      for (int a = 0; a < 3; a++) begin
        reg_addr = a[1:0];
        #1;
        checks++;
        if (reg_rdata !== 32'd0) begin
          errors++;
          $display("FAIL reset_rdata: addr %0d got %h, want 0", a, reg_rdata);
        end
      end
    end
    illop  = 1'b0;
    irq_in = '0;
    PC     = 32'd0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    reg_addr = 2'd1;
    #1;
    checks++;
    if (reg_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_pending: got %h, want 0", reg_rdata);
    end
  endtask

  task automatic test_basic_irq();
    reg_we = 1'b1; reg_addr = 2'd0; reg_wdata = 32'h01;
    PC = 32'h0000_0040;
    tick();
    reg_we = 1'b0;
    irq_in[0] = 1'b1;
    repeat (LAT) tick();
    expect_force(3'd4, 32'h0000_0040);
    tick();
    irq_in = '0;
    reg_addr = 2'd2; #1; checks++;
    if (reg_rdata !== 32'd0) begin errors++; $display("FAIL basic_cause: got %h, want 0", reg_rdata); end
    reg_addr = 2'd1; #1; checks++;
    if (reg_rdata !== 32'd0) begin errors++; $display("FAIL basic_pending: got %h, want 0", reg_rdata); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL basic_missed: %0d outstanding, want 0", sb.size()); sb.delete(); end
    return_user(32'h0000_0100);
  endtask

  task automatic test_priority();
    reg_we = 1'b1; reg_addr = 2'd0; reg_wdata = 32'h0C;
    tick();
    reg_we = 1'b0;
    irq_in = 8'h0E;
    repeat (LAT) tick();
    expect_force(3'd4, 32'h0000_0100);
    tick();
    irq_in = '0;
    reg_addr = 2'd2; #1; checks++;
    if (reg_rdata !== 32'd2) begin errors++; $display("FAIL prio_cause2: got %h, want 2", reg_rdata); end
    reg_addr = 2'd1; #1; checks++;
    if (reg_rdata !== 32'h0A) begin errors++; $display("FAIL prio_pending1: got %h, want 0a", reg_rdata); end
    PC = 32'h8000_0080;
    tick();
    PC = 32'h0000_0100;
    #1; checks++;
    if (force_en !== 1'b0) begin errors++; $display("FAIL prio_kernel_gate: got en=%b, want 0", force_en); end
    tick();
    expect_force(3'd4, 32'h0000_0100);
    tick();
    reg_addr = 2'd2; #1; checks++;
    if (reg_rdata !== 32'd3) begin errors++; $display("FAIL prio_cause3: got %h, want 3", reg_rdata); end
    reg_addr = 2'd1; #1; checks++;
    if (reg_rdata !== 32'h02) begin errors++; $display("FAIL prio_pending2: got %h, want 02", reg_rdata); end
    return_user(32'h0000_0100);
    checks++;
    if (force_en !== 1'b0) begin errors++; $display("FAIL prio_masked: got en=%b, want 0", force_en); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL prio_missed: %0d outstanding, want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_exception();
    PC = 32'h0000_1000;
    reg_we = 1'b1; reg_addr = 2'd0; reg_wdata = 32'h02;
    #1; checks++;
    if (force_en !== 1'b0) begin errors++; $display("FAIL mask_delay: got en=%b, want 0", force_en); end
    tick();
    reg_we = 1'b0;
    illop  = 1'b1;
    expect_force(3'd5, 32'h0000_1004);
    tick();
    illop = 1'b0;
    reg_addr = 2'd1; #1; checks++;
    if (reg_rdata !== 32'h02) begin errors++; $display("FAIL exc_pending: got %h, want 02", reg_rdata); end
    reg_addr = 2'd2; #1; checks++;
    if (reg_rdata !== 32'd3) begin errors++; $display("FAIL exc_cause: got %h, want 3", reg_rdata); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL exc_missed: %0d outstanding, want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_kernel();
    PC = 32'h8000_0020;
    #1; checks++;
    if (force_en !== 1'b0) begin errors++; $display("FAIL kern_gate_a: got en=%b, want 0", force_en); end
    tick();
    PC = 32'h0000_3000;
    #1; checks++;
    if (force_en !== 1'b0) begin errors++; $display("FAIL kern_state_gate: got en=%b, want 0", force_en); end
    tick();
    PC = 32'h8000_0020;
    for (int i = 0; i < 2; i++) begin
      #1; checks++;
      if (force_en !== 1'b0) begin errors++; $display("FAIL kern_pc_gate: got en=%b, want 0", force_en); end
      tick();
    end
    PC = 32'h0000_2000;
    expect_force(3'd4, 32'h0000_2000);
    tick();
    reg_addr = 2'd2; #1; checks++;
    if (reg_rdata !== 32'd1) begin errors++; $display("FAIL kern_cause: got %h, want 1", reg_rdata); end
    reg_addr = 2'd1; #1; checks++;
    if (reg_rdata !== 32'd0) begin errors++; $display("FAIL kern_pending: got %h, want 0", reg_rdata); end
    PC = 32'h8000_0020; illop = 1'b1;
    expect_force(3'd5, 32'h8000_0024);
    tick();
    PC = 32'hFFFF_FFFC;
    expect_force(3'd5, 32'h8000_0000);
    tick();
    illop = 1'b0;
    PC = 32'h8000_0040;
    irq_in[1] = 1'b1;
    repeat (LAT) tick();
    reg_addr = 2'd1; #1; checks++;
    if (reg_rdata !== 32'h02) begin errors++; $display("FAIL kern_pending2: got %h, want 02", reg_rdata); end
    PC = 32'h7FFF_FFFC; illop = 1'b1;
    expect_force(3'd5, 32'h0000_0000);
    tick();
    illop = 1'b0;
    PC = 32'h0000_3000;
    #1; checks++;
    if (force_en !== 1'b0) begin errors++; $display("FAIL kern_exc_stays: got en=%b, want 0", force_en); end
    tick();
    expect_force(3'd4, 32'h0000_3000);
    tick();
    irq_in = '0;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL kern_missed: %0d outstanding, want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_collisions();
    return_user(32'h0000_0200);
    PC = 32'h8000_0200;
    irq_in[1] = 1'b1;
    repeat (LAT) tick();
    irq_in = '0;
    repeat (4) tick();
    reg_addr = 2'd1; #1; checks++;
    if (reg_rdata !== 32'h02) begin errors++; $display("FAIL coll_setup: got %h, want 02", reg_rdata); end
    irq_in[1] = 1'b1;
    repeat (LAT - 1) tick();
    PC = 32'h0000_0200;
    expect_force(3'd4, 32'h0000_0200);
    tick();
    reg_addr = 2'd1; #1; checks++;
    if (reg_rdata !== 32'h02) begin errors++; $display("FAIL coll_ack_rise: got %h, want 02", reg_rdata); end
    irq_in = '0;
    PC = 32'h8000_0200;
    repeat (4) tick();
    irq_in[2] = 1'b1;
    repeat (LAT - 1) tick();
    reg_we = 1'b1; reg_addr = 2'd1; reg_wdata = 32'h06;
    tick();
    reg_we = 1'b0;
    #1; checks++;
    if (reg_rdata !== 32'h04) begin errors++; $display("FAIL coll_w1c_rise: got %h, want 04", reg_rdata); end
    reg_we = 1'b1; reg_addr = 2'd3; reg_wdata = 32'hFFFF_FFFF;
    tick();
    reg_we = 1'b0;
    #1; checks++;
    if (reg_rdata !== 32'd0) begin errors++; $display("FAIL addr3_read: got %h, want 0", reg_rdata); end
    reg_addr = 2'd0; #1; checks++;
    if (reg_rdata !== 32'h02) begin errors++; $display("FAIL addr3_mask: got %h, want 02", reg_rdata); end
    reg_we = 1'b1; reg_addr = 2'd1; reg_wdata = 32'h04;
    tick();
    reg_we = 1'b0;
    irq_in = '0;
    #1; checks++;
    if (reg_rdata !== 32'd0) begin errors++; $display("FAIL w1c_clear: got %h, want 0", reg_rdata); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL coll_missed: %0d outstanding, want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_latency();
    int n;
    n = 0;
    reg_addr = 2'd1;
    irq_in[5] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n++;
      if (reg_rdata[5]) break;
    end
    checks++;
    if (n != LAT || reg_rdata[5] !== 1'b1) begin
      errors++;
      $display("FAIL latency: got %0d edges (bit=%b), want %0d", n, reg_rdata[5], LAT);
    end
  endtask

  task automatic test_reset_mid();
    reset  = 1'b0;
    irq_in = '0;
    tick();
    reset = 1'b1;
    tick();
    for (int a = 0; a < 3; a++) begin
      reg_addr = a[1:0];
      #1; checks++;
      if (reg_rdata !== 32'd0) begin errors++; $display("FAIL midreset_rdata: addr %0d got %h, want 0", a, reg_rdata); end
    end
    reg_we = 1'b1; reg_addr = 2'd0; reg_wdata = 32'h01;
    PC = 32'h0000_0400;
    tick();
    reg_we = 1'b0;
    irq_in[0] = 1'b1;
    repeat (LAT) tick();
    expect_force(3'd4, 32'h0000_0400);
    tick();
    irq_in = '0;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL midreset_missed: %0d outstanding, want 0", sb.size()); sb.delete(); end
  endtask

  initial begin
    test_reset();
    test_basic_irq();
    test_priority();
    test_exception();
    test_kernel();
    test_collisions();
    test_latency();
    test_reset_mid();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
